top_bin_to_bcd: RTL and testbench

TOP_BIN_TO_BCD -- requirements
Module: top_bin_to_bcd

---
 rtl/top_bin_to_bcd_pkg.sv | 19 +
 rtl/top_bin_to_bcd_add3_digit.sv | 11 +
 rtl/top_bin_to_bcd.sv | 95 +++++++++
 tb/tb_top_bin_to_bcd.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/top_bin_to_bcd_pkg.sv
// Shared types for the sequential binary-to-BCD converter: FSM state and BCD digit.
package top_bin_to_bcd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t ADD3_THRESH = 4'd5;
  localparam bcd_digit_t ADD3_VALUE  = 4'd3;

  // Double-dabble correction: a digit >= 5 would exceed 9 after the next shift.
  function automatic bcd_digit_t add3(input bcd_digit_t d);
    return (d >= ADD3_THRESH) ? bcd_digit_t'(d + ADD3_VALUE) : d;
  endfunction

endpackage

// File: rtl/top_bin_to_bcd_add3_digit.sv
// Single-digit add-3 correction cell used by the double-dabble datapath.
module bcd_add3_digit
  import top_bin_to_bcd_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t digit_c_o
);

  assign digit_c_o = add3(digit_i);

endmodule

// File: rtl/top_bin_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock, MSB first.
// Optional overflow flag output enabled by defining TOP_BIN_TO_BCD_OVF_EN.
module top_bin_to_bcd
  import top_bin_to_bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 15,
  parameter int unsigned DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BIN_W-1:0]      binaryNumber,
  output logic [4*DIGITS-1:0]   BinaryDecimal,
  output logic                  enaOut
`ifdef TOP_BIN_TO_BCD_OVF_EN
  ,
  output logic                  ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned BCD_W = 4 * DIGITS;

  state_t             state_q;
  logic [BIN_W-1:0]   shift_q;
  logic [BCD_W-1:0]   scratch_q;
  logic [BCD_W-1:0]   adj_c;
  logic [BCD_W-1:0]   scratch_d;
  logic [CNT_W-1:0]   cnt_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit_i   (scratch_q[4*g +: 4]),
      .digit_c_o (adj_c[4*g +: 4])
    );
  end

  // Corrected scratch shifted left with the next binary bit; the top bit falls off.
  assign scratch_d = BCD_W'({adj_c, shift_q[BIN_W-1]});

`ifdef TOP_BIN_TO_BCD_OVF_EN
  logic carry_c;
  logic ovf_acc_q;

  assign carry_c = adj_c[BCD_W-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      scratch_q     <= '0;
      cnt_q         <= '0;
      BinaryDecimal <= '0;
      enaOut        <= 1'b0;
`ifdef TOP_BIN_TO_BCD_OVF_EN
      ovf_acc_q     <= 1'b0;
      ovf           <= 1'b0;
`endif
    end else begin
      enaOut <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            shift_q   <= binaryNumber;
            scratch_q <= '0;
            cnt_q     <= CNT_W'(BIN_W);
            state_q   <= CONV;
`ifdef TOP_BIN_TO_BCD_OVF_EN
            ovf_acc_q <= 1'b0;
`endif
          end
        end
        CONV: begin
          scratch_q <= scratch_d;
          shift_q   <= shift_q << 1;
          cnt_q     <= cnt_q - CNT_W'(1);
`ifdef TOP_BIN_TO_BCD_OVF_EN
          ovf_acc_q <= ovf_acc_q | carry_c;
`endif
          if (cnt_q == CNT_W'(1)) begin
            BinaryDecimal <= scratch_d;
            enaOut        <= 1'b1;
            state_q       <= IDLE;
`ifdef TOP_BIN_TO_BCD_OVF_EN
            ovf           <= ovf_acc_q | carry_c;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_top_bin_to_bcd.sv
// Scoreboard bench for top_bin_to_bcd: stimulus pushes expected results, a monitor checks pulses.
module tb_top_bin_to_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [14:0] bin = '0;
  logic [23:0] bcd;
  logic        ena;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [23:0] hold_exp = '0;

  typedef struct {
    logic [23:0] val;
    int          due;
  } exp_t;

  exp_t sb[$];

`ifdef TOP_BIN_TO_BCD_OVF_EN
  logic       ovf;
  logic       load8 = 1'b0;
  logic [7:0] bin8 = '0;
  logic [7:0] bcd8;
  logic       ena8;
  logic       ovf8;
`endif

  top_bin_to_bcd dut (
    .clk           (clk),
    .rst           (rst),
    .load          (load),
    .binaryNumber  (bin),
    .BinaryDecimal (bcd),
    .enaOut        (ena)
`ifdef TOP_BIN_TO_BCD_OVF_EN
    ,
    .ovf           (ovf)
`endif
  );

`ifdef TOP_BIN_TO_BCD_OVF_EN
  top_bin_to_bcd #(.BIN_W(8), .DIGITS(2)) dut8 (
    .clk           (clk),
    .rst           (rst),
    .load          (load8),
    .binaryNumber  (bin8),
    .BinaryDecimal (bcd8),
    .enaOut        (ena8),
    .ovf           (ovf8)
  );
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle load and record the expected result; input scrambled afterwards.
  task automatic start(input logic [14:0] v, input logic [23:0] exp);
    exp_t e;
    bin  = v;
    load = 1'b1;
    e.val = exp;
    e.due = cyc + 16;
    sb.push_back(e);
    step(1);
    load = 1'b0;
    bin  = 15'($urandom);
  endtask

  // Monitor: pop on every enaOut pulse, otherwise the output must hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ena) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 32'(ena), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result", 32'(bcd), 32'(e.val));
          chk("latency", 32'(cyc), 32'(e.due));
          hold_exp = e.val;
`ifdef TOP_BIN_TO_BCD_OVF_EN
          chk("ovf_main", 32'(ovf), 32'd0);
`endif
        end
      end else begin
        chk("hold", 32'(bcd), 32'(hold_exp));
      end
      if (rst) begin
        hold_exp = '0;
        sb.delete();
      end
    end
  end

  initial begin
    exp_t e;
    int   c;
    step(2);
    rst = 1'b0;
    chk("reset_bcd", 32'(bcd), 32'd0);
    chk("reset_ena", 32'(ena), 32'd0);

    start(15'd12345, 24'h012345);
    step(20);
    start(15'd32767, 24'h032767);
    step(20);
    start(15'd0, 24'h000000);
    step(20);

    // Second load during conversion must be ignored.
    start(15'd9999, 24'h009999);
    step(2);
    bin  = 15'd1;
    load = 1'b1;
    step(1);
    load = 1'b0;
    step(20);

    // Reset mid-conversion aborts without a pulse.
    start(15'd500, 24'h000500);
    step(6);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("abort_bcd", 32'(bcd), 32'd0);
    step(20);
    start(15'd42, 24'h000042);
    step(20);

    // Held load: back-to-back conversions every 16 cycles.
    bin  = 15'd7;
    load = 1'b1;
    c    = cyc;
    for (int i = 1; i <= 3; i++) begin
      e.val = 24'h000007;
      e.due = c + 16 * i;
      sb.push_back(e);
    end
    step(33);
    load = 1'b0;
    step(20);

`ifdef TOP_BIN_TO_BCD_OVF_EN
    bin8  = 8'd255;
    load8 = 1'b1;
    step(1);
    load8 = 1'b0;
    step(8);
    chk("ovf8_ena", 32'(ena8), 32'd1);
    chk("ovf8_bcd", 32'(bcd8), 32'h55);
    chk("ovf8_flag", 32'(ovf8), 32'd1);
    step(2);
    bin8  = 8'd99;
    load8 = 1'b1;
    step(1);
    load8 = 1'b0;
    step(8);
    chk("ovf8_ena99", 32'(ena8), 32'd1);
    chk("ovf8_bcd99", 32'(bcd8), 32'h99);
    chk("ovf8_flag99", 32'(ovf8), 32'd0);
    step(2);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
